// File: rtl/backward_arbiter_if.sv
// Response-path handshake bundle between the slave response FIFOs, one master's
// response FIFO and its backward_arbiter. Extra ports appear with BACKWARD_ARB_BEAT_CNT_EN.
interface backward_arbiter_if #(
    parameter int masters = 2,
    parameter int slaves  = 2
);
    localparam int SW = $clog2(slaves);
    localparam int MW = $clog2(masters);

    logic [0:slaves-1]         slave_fifo_empty;
    logic [0:slaves-1][MW-1:0] slave_master_dest;
    logic [0:slaves-1]         slave_resp_last;
    logic                      master_fifo_full;
    logic [slaves-1:0]         pop_slave;
    logic                      push_to_fifo;
    logic [SW-1:0]             grant_slave_number;
    logic                      locked;
`ifdef BACKWARD_ARB_BEAT_CNT_EN
    logic [8:0]                beat_count;
    logic                      protocol_error;
`endif

    // Arbiter side.
    modport master (
        input  slave_fifo_empty, slave_master_dest, slave_resp_last, master_fifo_full,
`ifdef BACKWARD_ARB_BEAT_CNT_EN
        output beat_count, protocol_error,
`endif
        output pop_slave, push_to_fifo, grant_slave_number, locked
    );

    // FIFO / environment side.
    modport slave (
        output slave_fifo_empty, slave_master_dest, slave_resp_last, master_fifo_full,
`ifdef BACKWARD_ARB_BEAT_CNT_EN
        input  beat_count, protocol_error,
`endif
        input  pop_slave, push_to_fifo, grant_slave_number, locked
    );
endinterface

// File: rtl/backward_arbiter.sv
// Per-master response arbiter: round-robin over slave FIFOs, grant held for a whole burst.
// Optional beat counter / protocol error outputs when BACKWARD_ARB_BEAT_CNT_EN is defined.
module backward_arbiter #(
    parameter int masters            = 2,
    parameter int slaves             = 2,
    parameter int i_am_master_number = 0
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    backward_arbiter_if.master    bus
);
    localparam int SW = $clog2(slaves);
    localparam int MW = $clog2(masters);

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] rr_ptr_q, rr_ptr_d;
    logic [SW-1:0] lock_slave_q, lock_slave_d;

    logic [slaves-1:0] req;
    logic [SW-1:0]     cand;
    logic              cand_valid;
    int                scan_idx;

    logic              push;
    logic [SW-1:0]     grant;
    logic [slaves-1:0] pop;
    logic              last_beat;

    function automatic logic [SW-1:0] next_slave(input logic [SW-1:0] s);
        return (int'(s) == slaves - 1) ? '0 : s + 1'b1;
    endfunction

    generate
        for (genvar gi = 0; gi < slaves; gi++) begin : g_req
            assign req[gi] = ~bus.slave_fifo_empty[gi] &
                             (bus.slave_master_dest[gi] == MW'(i_am_master_number));
        end
    endgenerate

    // Scan downwards so the requester closest to rr_ptr is the one left in cand.
    always_comb begin
        cand       = '0;
        cand_valid = 1'b0;
        scan_idx   = 0;
        for (int k = slaves - 1; k >= 0; k--) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= slaves) scan_idx = scan_idx - slaves;
            if (req[scan_idx]) begin
                cand       = SW'(scan_idx);
                cand_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        lock_slave_d = lock_slave_q;
        push         = 1'b0;
        grant        = '0;
        last_beat    = 1'b0;
        if (!ARESET) begin
            case (state_q)
                IDLE: begin
                    grant = cand;
                    push  = cand_valid & ~bus.master_fifo_full;
                    if (push) begin
                        if (bus.slave_resp_last[cand]) begin
                            rr_ptr_d = next_slave(cand);
                        end else begin
                            state_d      = BURST;
                            lock_slave_d = cand;
                        end
                    end
                end
                BURST: begin
                    // Only the locked slave may move until its last beat.
                    grant = lock_slave_q;
                    push  = req[lock_slave_q] & ~bus.master_fifo_full;
                    if (push && bus.slave_resp_last[lock_slave_q]) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_slave(lock_slave_q);
                    end
                end
                default: state_d = IDLE;
            endcase
            last_beat = push & bus.slave_resp_last[grant];
        end
    end

    always_comb begin
        pop = '0;
        if (push) pop[grant] = 1'b1;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            lock_slave_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_slave_q <= lock_slave_d;
        end
    end

    assign bus.push_to_fifo       = push;
    assign bus.pop_slave          = pop;
    assign bus.grant_slave_number = grant;
    assign bus.locked             = (state_q == BURST) & ~ARESET;

`ifdef BACKWARD_ARB_BEAT_CNT_EN
    logic [8:0] beat_count_q, beat_count_d;
    logic       protocol_error_q, protocol_error_d;

    always_comb begin
        beat_count_d     = beat_count_q;
        protocol_error_d = protocol_error_q;
        if (push) begin
            if (last_beat) begin
                beat_count_d = '0;
            end else begin
                // A non-last beat at 255 means the burst needs a 257th beat.
                if (beat_count_q == 9'd255) protocol_error_d = 1'b1;
                if (beat_count_q != 9'h1FF) beat_count_d = beat_count_q + 9'd1;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            beat_count_q     <= '0;
            protocol_error_q <= 1'b0;
        end else begin
            beat_count_q     <= beat_count_d;
            protocol_error_q <= protocol_error_d;
        end
    end

    assign bus.beat_count     = beat_count_q;
    assign bus.protocol_error = protocol_error_q;
`else
    logic unused_last_beat;
    assign unused_last_beat = last_beat;
`endif
endmodule

// File: tb/tb_backward_arbiter.sv
// Bench for backward_arbiter (masters=2, slaves=3, serving master 0): slave FIFOs are
// modelled as queues of beats; expected grants come from the round-robin/burst-lock rules.
module tb_backward_arbiter;
    localparam int NM = 2;
    localparam int NS = 3;

    typedef struct packed {
        logic dest;
        logic last;
    } beat_t;

    logic ACLK   = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;

    backward_arbiter_if #(.masters(NM), .slaves(NS)) bus ();

    backward_arbiter #(
        .masters(NM),
        .slaves(NS),
        .i_am_master_number(0)
    ) dut (
        .ACLK  (ACLK),
        .ARESET(ARESET),
        .bus   (bus)
    );

    beat_t       q[NS][$];
    int          owner = -1;
    int          ptr   = 0;
    int          cnt   = 0;
    logic        err   = 1'b0;
    logic [NS-1:0] stall_mask = '0;
    logic        full_r = 1'b0;
    logic        rst_r  = 1'b1;
    bit          rand_stall = 1'b0;
    int          n_vec  = 0;
    int          n_miss = 0;
    logic        obs_push, obs_locked;
    logic [1:0]  obs_grant;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_resp(input int s, input int dest, input int n);
        beat_t bt;
        for (int b = 0; b < n; b++) begin
            bt.dest = 1'(dest);
            bt.last = (b == n - 1);
            q[s].push_back(bt);
        end
    endtask

    task automatic cycle();
        logic [NS-1:0] present, req, exp_pop;
        logic          exp_push;
        int            g, found, j;
        beat_t         b;
        @(negedge ACLK);
        ARESET = rst_r;
        bus.master_fifo_full = full_r;
        for (int i = 0; i < NS; i++) begin
            present[i] = (q[i].size() > 0) && !stall_mask[i] &&
                         !(rand_stall && $urandom_range(0, 3) == 0);
            bus.slave_fifo_empty[i] = ~present[i];
            if (present[i]) begin
                bus.slave_master_dest[i] = q[i][0].dest;
                bus.slave_resp_last[i]   = q[i][0].last;
                req[i] = (q[i][0].dest == 1'b0);
            end else begin
                bus.slave_master_dest[i] = 1'($urandom_range(0, 1));
                bus.slave_resp_last[i]   = 1'($urandom_range(0, 1));
                req[i] = 1'b0;
            end
        end
        g = 0;
        exp_push = 1'b0;
        if (!rst_r) begin
            if (owner >= 0) begin
                g = owner;
                exp_push = req[owner] && !full_r;
            end else begin
                found = -1;
                for (int k = 0; k < NS; k++) begin
                    j = (ptr + k) % NS;
                    if (found < 0 && req[j]) found = j;
                end
                if (found >= 0) begin
                    g = found;
                    exp_push = !full_r;
                end
            end
        end
        exp_pop = '0;
        if (exp_push) exp_pop[g] = 1'b1;
        #1;
        obs_push   = bus.push_to_fifo;
        obs_grant  = bus.grant_slave_number;
        obs_locked = bus.locked;
        $display("t=%0t rst=%0b full=%0b req=%b push=%0b pop=%b grant=%0d locked=%0b",
                 $time, rst_r, full_r, req, obs_push, bus.pop_slave, obs_grant, obs_locked);
        chk("push_to_fifo", 16'(obs_push), 16'(exp_push));
        chk("pop_slave", 16'(bus.pop_slave), 16'(exp_pop));
        chk("locked", 16'(obs_locked), 16'(!rst_r && owner >= 0));
        if (exp_push) chk("grant", 16'(obs_grant), 16'(g));
        if (rst_r) chk("grant_in_reset", 16'(obs_grant), 16'd0);
`ifdef BACKWARD_ARB_BEAT_CNT_EN
        if (!rst_r) begin
            chk("beat_count", 16'(bus.beat_count), 16'(cnt));
            chk("protocol_error", 16'(bus.protocol_error), 16'(err));
        end
`endif
        @(posedge ACLK);
        if (rst_r) begin
            owner = -1;
            ptr   = 0;
            cnt   = 0;
            err   = 1'b0;
        end else begin
            if (exp_push) begin
                b = q[g].pop_front();
                if (!b.last && cnt == 255) err = 1'b1;
                if (b.last) begin
                    owner = -1;
                    ptr   = (g + 1) % NS;
                    cnt   = 0;
                end else begin
                    owner = g;
                    if (cnt < 511) cnt++;
                end
            end
            // Heads addressed to the other master drain through its own arbiter.
            for (int i = 0; i < NS; i++)
                if (present[i] && !req[i] && $urandom_range(0, 1) == 1) b = q[i].pop_front();
        end
    endtask

    initial begin
        bus.slave_fifo_empty  = '1;
        bus.slave_master_dest = '0;
        bus.slave_resp_last   = '0;
        bus.master_fifo_full  = 1'b0;

        // Reset
        rst_r = 1'b1;
        add_resp(0, 0, 1);
        cycle();
        cycle();
        rst_r = 1'b0;

        // Two single-beat responses: slave 0 then slave 1
        add_resp(1, 0, 1);
        cycle(); chk("s1_first_grant", 16'(obs_grant), 16'd0);
        cycle(); chk("s1_second_grant", 16'(obs_grant), 16'd1);
        cycle(); chk("s1_idle_no_push", 16'(obs_push), 16'd0);

        // rr_ptr=2 with req on 0 and 1: scan wraps to slave 0
        add_resp(0, 0, 1); add_resp(1, 0, 1);
        cycle(); chk("wrap_scan_grant0", 16'(obs_grant), 16'd0);
        cycle();
        add_resp(2, 0, 1);
        cycle(); chk("grant_slave2", 16'(obs_grant), 16'd2);
        add_resp(1, 0, 1); add_resp(0, 0, 1);
        cycle(); chk("ptr_wrapped_to0", 16'(obs_grant), 16'd0);
        cycle();

        // 4-beat burst on slave 1 while slave 0 keeps requesting
        add_resp(1, 0, 4); add_resp(0, 0, 1); add_resp(0, 0, 1);
        stall_mask = 3'b001;
        cycle(); chk("burst_start", 16'(obs_grant), 16'd1);
        stall_mask = 3'b000;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("burst_hold_grant", 16'(obs_grant), 16'd1);
            chk("burst_locked", 16'(obs_locked), 16'd1);
        end
        cycle(); chk("after_burst_grant0", 16'(obs_grant), 16'd0);
        cycle(); cycle();

        // Locked slave goes empty for 3 cycles mid-burst
        add_resp(1, 0, 4); add_resp(0, 0, 1);
        stall_mask = 3'b001;
        cycle(); cycle();
        stall_mask = 3'b010;
        for (int i = 0; i < 3; i++) begin
            cycle(); chk("gap_no_push", 16'(obs_push), 16'd0);
        end
        stall_mask = 3'b000;
        cycle(); chk("burst_resume", 16'(obs_grant), 16'd1);
        repeat (3) cycle();

        // Full master FIFO blocks transfers
        add_resp(0, 0, 1); add_resp(2, 0, 1);
        full_r = 1'b1;
        cycle(); chk("full_blocks_1", 16'(obs_push), 16'd0);
        cycle(); chk("full_blocks_2", 16'(obs_push), 16'd0);
        full_r = 1'b0;
        cycle(); chk("full_released", 16'(obs_push), 16'd1);
        cycle();

        // Reset mid-burst after 2 of 4 beats
        add_resp(1, 0, 4);
        stall_mask = 3'b101;
        cycle(); cycle();
        rst_r = 1'b1;
        cycle(); chk("reset_no_push", 16'(obs_push), 16'd0);
        rst_r = 1'b0;
        cycle(); chk("post_reset_unlocked", 16'(obs_locked), 16'd0);
        chk("post_reset_fresh_grant", 16'(obs_grant), 16'd1);
        stall_mask = 3'b000;
        repeat (3) cycle();

`ifdef BACKWARD_ARB_BEAT_CNT_EN
        // 257-beat burst overflows the beat counter
        add_resp(2, 0, 257);
        stall_mask = 3'b011;
        repeat (257) cycle();
        @(negedge ACLK);
        chk("protocol_error_set", 16'(bus.protocol_error), 16'd1);
        chk("beat_count_cleared", 16'(bus.beat_count), 16'd0);
        stall_mask = 3'b000;
`endif

        // Randomized traffic
        rand_stall = 1'b1;
        for (int n = 0; n < 800; n++) begin
            full_r = ($urandom_range(0, 4) == 0);
            rst_r  = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < NS; i++)
                if (q[i].size() < 6 && $urandom_range(0, 3) == 0)
                    add_resp(i, $urandom_range(0, 1), $urandom_range(1, 4));
            cycle();
        end
        rst_r  = 1'b0;
        full_r = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
